// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns {a,b,c,d,e,f,g,dp} and scan states.
package seg7_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_A     = 8'b1110_1110;
    localparam logic [7:0] SEG_B     = 8'b0011_1110;
    localparam logic [7:0] SEG_C     = 8'b1001_1100;
    localparam logic [7:0] SEG_D     = 8'b0111_1010;
    localparam logic [7:0] SEG_E     = 8'b1001_1110;
    localparam logic [7:0] SEG_F     = 8'b1000_1110;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    // Pattern for one hex digit with the dp bit cleared.
    function automatic logic [7:0] seg_pattern(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'h0: p = SEG_0;
            4'h1: p = SEG_1;
            4'h2: p = SEG_2;
            4'h3: p = SEG_3;
            4'h4: p = SEG_4;
            4'h5: p = SEG_5;
            4'h6: p = SEG_6;
            4'h7: p = SEG_7;
            4'h8: p = SEG_8;
            4'h9: p = SEG_9;
            4'hA: p = SEG_A;
            4'hB: p = SEG_B;
            4'hC: p = SEG_C;
            4'hD: p = SEG_D;
            4'hE: p = SEG_E;
            default: p = SEG_F;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational digit encoder: hex value + decimal point + blank -> segment pattern.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg    = seg_pattern(bcd);
            seg[0] = dp;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display driver with inter-digit blanking and
// frame-synchronous double buffering of the displayed digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]   zero_up;
    logic                    all_zero;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [7:0]              lut_seg;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pend_bcd_d   = load ? bcd_in : pend_bcd_q;
        pend_dp_d    = load ? dp_in  : pend_dp_q;
        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: a load on this very cycle bypasses the pending buffer.
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        act_bcd_d    = load ? bcd_in : pend_bcd_q;
                        act_dp_d     = load ? dp_in  : pend_dp_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_BLANK;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        all_zero  = 1'b1;
        zero_up   = '0;
        cur_bcd   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero   = all_zero & (act_bcd_d[4*k +: 4] == 4'd0);
            zero_up[k] = all_zero;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                cur_bcd   = act_bcd_d[4*k +: 4];
                cur_dp    = act_dp_d[k];
                cur_blank = (BLANK_LZ != 0) && (k > 0) && zero_up[k];
            end
        end
    end

    seg7_lut u_lut (
        .bcd   (cur_bcd),
        .dp    (cur_dp),
        .blank (cur_blank),
        .seg   (lut_seg)
    );

    always_comb begin
        seg_d = (state_d == S_DRIVE) ? lut_seg : SEG_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_n_d[k] = !((state_d == S_DRIVE) && (idx_d == IDX_W'(k)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            act_bcd_q    <= '0;
            act_dp_q     <= '0;
            seg_q        <= SEG_BLANK;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 2 digits, REFRESH_DIV=4, BLANK_CYC=2 (12-cycle frame).
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bcd_in = 8'h00;
    logic [1:0] dp_in = 2'b00;
    logic       load = 1'b0;
    logic [7:0] seg, seg_b;
    logic [1:0] an_n, an_n_b;
    logic       frame_done, frame_done_b;

    int checks = 0;
    int errors = 0;
    int ph = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYC(2), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .seg(seg), .an_n(an_n), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYC(2), .BLANK_LZ(0)) dut_nolz (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .seg(seg_b), .an_n(an_n_b), .frame_done(frame_done_b)
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; ph is the frame offset.
    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 12;
    endtask

    task automatic goto(input int target);
        while (ph != target) tick();
    endtask

    task automatic do_load(input logic [7:0] b, input logic [1:0] d);
        bcd_in = b;
        dp_in  = d;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    // From offset 0: check both digit phases of both DUTs, end at next offset 0 on frame_done.
    task automatic frame_check(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s0b, input logic [7:0] s1b);
        goto(3);
        chk8({tag, "_an_d0"}, {6'b0, an_n}, 8'b10);
        chk8({tag, "_seg_d0"}, seg, s0);
        chk8({tag, "_seg_d0_nolz"}, seg_b, s0b);
        goto(9);
        chk8({tag, "_an_d1"}, {6'b0, an_n}, 8'b01);
        chk8({tag, "_seg_d1"}, seg, s1);
        chk8({tag, "_seg_d1_nolz"}, seg_b, s1b);
        goto(0);
        chk8({tag, "_frame_done"}, {7'b0, frame_done}, 8'd1);
    endtask

    initial begin
        logic [1:0] exp_an;
        logic [7:0] exp_seg;

        // Reset held three cycles
        rst = 1'b1;
        repeat (3) tick();
        chk8("rst_seg", seg, 8'h00);
        chk8("rst_an", {6'b0, an_n}, 8'b11);
        chk8("rst_fd", {7'b0, frame_done}, 8'd0);
        rst = 1'b0;
        ph  = 0;

        // First frame after reset: zero buffers, digit 1 leading-zero blanked
        for (int i = 0; i < 12; i++) begin
            exp_an  = (i >= 2 && i <= 5) ? 2'b10 : (i >= 8) ? 2'b01 : 2'b11;
            exp_seg = (i >= 2 && i <= 5) ? 8'b1111_1100 : 8'h00;
            chk8($sformatf("scan_an_%0d", i), {6'b0, an_n}, {6'b0, exp_an});
            chk8($sformatf("scan_seg_%0d", i), seg, exp_seg);
            chk8($sformatf("scan_fd_%0d", i), {7'b0, frame_done}, 8'd0);
            tick();
        end
        chk8("first_fd", {7'b0, frame_done}, 8'd1);

        // 0x47
        do_load(8'h47, 2'b00);
        goto(0);
        chk8("l47_fd", {7'b0, frame_done}, 8'd1);
        frame_check("l47", 8'b1110_0000, 8'b0110_0110, 8'b1110_0000, 8'b0110_0110);

        // Leading-zero blanking
        do_load(8'h05, 2'b00);
        goto(0);
        frame_check("l05", 8'b1011_0110, 8'h00, 8'b1011_0110, 8'b1111_1100);
        do_load(8'h00, 2'b00);
        goto(0);
        frame_check("l00", 8'b1111_1100, 8'h00, 8'b1111_1100, 8'b1111_1100);

        // Tear-free: load mid digit-0 drive, old value stays for the frame
        goto(3);
        do_load(8'h12, 2'b00);
        chk8("tear_d0_old", seg, 8'b1111_1100);
        goto(9);
        chk8("tear_d1_old", seg, 8'h00);
        goto(0);
        frame_check("l12", 8'b1101_1010, 8'b0110_0000, 8'b1101_1010, 8'b0110_0000);

        // Two loads in one frame: only the last reaches the display
        do_load(8'h34, 2'b00);
        goto(7);
        do_load(8'h56, 2'b00);
        goto(9);
        chk8("multi_d1_old", seg, 8'b0110_0000);
        goto(0);
        frame_check("l56", 8'b1011_1110, 8'b1011_0110, 8'b1011_1110, 8'b1011_0110);

        // Load on the wrap cycle bypasses into the active buffer
        goto(11);
        do_load(8'h89, 2'b00);
        chk8("bypass_fd", {7'b0, frame_done}, 8'd1);
        frame_check("l89", 8'b1111_0110, 8'b1111_1110, 8'b1111_0110, 8'b1111_1110);
        frame_check("l89_pend", 8'b1111_0110, 8'b1111_1110, 8'b1111_0110, 8'b1111_1110);

        // Hex digits with decimal point on digit 0
        do_load(8'hAF, 2'b01);
        goto(0);
        frame_check("lAF", 8'b1000_1111, 8'b1110_1110, 8'b1000_1111, 8'b1110_1110);

        // Mid-frame reset beats a simultaneous load
        goto(5);
        bcd_in = 8'h99;
        load   = 1'b1;
        rst    = 1'b1;
        tick();
        load   = 1'b0;
        chk8("mrst_seg", seg, 8'h00);
        chk8("mrst_an", {6'b0, an_n}, 8'b11);
        chk8("mrst_fd", {7'b0, frame_done}, 8'd0);
        rst = 1'b0;
        ph  = 0;
        frame_check("mrst", 8'b1111_1100, 8'h00, 8'b1111_1100, 8'b1111_1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
